lamp_phase_controller: RTL

Two-road intersection sequencer that drives two RGY lamp heads: main road (NS) and side road (EW). It uses the team's one-hot RGY encoding (red=100, green=010, yellow=001, bit order [0:2]). It adds timed phases, a side-road car sensor, a latched pedestrian request with acknowledge, and an emergency all-red override. It sits above the single-lamp cycler and replaces its fixed rotation with a timed, request-driven schedule.

---
 rtl/lamp_phase_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lamp_phase_controller.sv
// Two-road intersection sequencer: timed NS/EW phases, side-road sensor,
// latched pedestrian request with acknowledge, and emergency all-red override.
//
// state    | meaning
// ---------+------------------------------------------------------------
// NS_G     | main road green, held past minimum until side or ped request
// NS_Y     | main road yellow
// ALLRED_A | clearance before EW green or walk
// EW_G     | side road green, fixed duration
// EW_Y     | side road yellow
// ALLRED_B | clearance before NS green (also the reset/restart state)
// WALK     | pedestrian walk, all vehicles red
// EMERG    | emergency all-red, held while emergency is asserted
module lamp_phase_controller #(
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 6,
   parameter int CNT_W        = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       side_req,
   input  logic       ped_req,
   input  logic       emergency,
   output logic [0:2] ns_light,
   output logic [0:2] ew_light,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_G     = 3'd0,
      NS_Y     = 3'd1,
      ALLRED_A = 3'd2,
      EW_G     = 3'd3,
      EW_Y     = 3'd4,
      ALLRED_B = 3'd5,
      WALK     = 3'd6,
      EMERG    = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_TICKS - 1);

   localparam logic [0:2] RED = 3'b100;
   localparam logic [0:2] GRN = 3'b010;
   localparam logic [0:2] YEL = 3'b001;

   state_t           state;
   logic [CNT_W-1:0] timer;
   logic             ped_pend;
   logic             emerg_pend;
   logic             expired;

   assign expired = (timer == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ALLRED_B;
         timer      <= LD_ALLRED;
         ped_pend   <= 1'b0;
         ped_ack    <= 1'b0;
         emerg_pend <= 1'b0;
      end else begin
         ped_ack <= 1'b0;
         if (timer != '0)
            timer <= timer - CNT_W'(1);

         if (ped_req && !ped_pend && state != WALK) begin
            ped_pend <= 1'b1;
            ped_ack  <= 1'b1;
         end

         // emerg_pend remembers an emergency seen during green/yellow so the
         // yellow still completes before the all-red override takes over
         case (state)
            NS_G: begin
               if (emergency) begin
                  state      <= NS_Y;
                  timer      <= LD_YELLOW;
                  emerg_pend <= 1'b1;
               end else if (expired && (side_req || ped_pend)) begin
                  state <= NS_Y;
                  timer <= LD_YELLOW;
               end
            end
            NS_Y: begin
               if (expired) begin
                  if (emergency || emerg_pend) begin
                     state      <= EMERG;
                     emerg_pend <= 1'b0;
                  end else begin
                     state <= ALLRED_A;
                     timer <= LD_ALLRED;
                  end
               end else if (emergency) begin
                  emerg_pend <= 1'b1;
               end
            end
            ALLRED_A: begin
               if (emergency) begin
                  state <= EMERG;
               end else if (expired) begin
                  if (ped_pend) begin
                     state    <= WALK;
                     timer    <= LD_WALK;
                     ped_pend <= 1'b0;
                  end else begin
                     state <= EW_G;
                     timer <= LD_GREEN;
                  end
               end
            end
            EW_G: begin
               if (emergency) begin
                  state      <= EW_Y;
                  timer      <= LD_YELLOW;
                  emerg_pend <= 1'b1;
               end else if (expired) begin
                  state <= EW_Y;
                  timer <= LD_YELLOW;
               end
            end
            EW_Y: begin
               if (expired) begin
                  if (emergency || emerg_pend) begin
                     state      <= EMERG;
                     emerg_pend <= 1'b0;
                  end else begin
                     state <= ALLRED_B;
                     timer <= LD_ALLRED;
                  end
               end else if (emergency) begin
                  emerg_pend <= 1'b1;
               end
            end
            ALLRED_B: begin
               if (emergency) begin
                  state <= EMERG;
               end else if (expired) begin
                  state <= NS_G;
                  timer <= LD_GREEN;
               end
            end
            WALK: begin
               // an aborted walk is owed to the pedestrian again
               if (emergency) begin
                  state    <= EMERG;
                  ped_pend <= 1'b1;
               end else if (expired) begin
                  state <= ALLRED_B;
                  timer <= LD_ALLRED;
               end
            end
            EMERG: begin
               if (!emergency) begin
                  state <= ALLRED_B;
                  timer <= LD_ALLRED;
               end
            end
         endcase
      end
   end

   always_comb begin
      ns_light = RED;
      ew_light = RED;
      walk     = 1'b0;
      case (state)
         NS_G:    ns_light = GRN;
         NS_Y:    ns_light = YEL;
         EW_G:    ew_light = GRN;
         EW_Y:    ew_light = YEL;
         WALK:    walk     = 1'b1;
         default: ;
      endcase
   end

   assign phase = state;

endmodule
